data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_pkg.sv | 50 +++++
 rtl/data_mem_responder_lane_align.sv | 57 +++++
 rtl/data_mem_responder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: access-size encodings,
// response error codes, FSM state encoding, the latched request record and
// the error-classification rule used both when writing memory and when
// building the response.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_RANGE    = 2'b10,
    ERR_SIZE     = 2'b11
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // Priority: illegal size, then misalignment, then word index past the end.
  function automatic err_e calc_err(input logic [1:0] size,
                                    input logic [31:0] addr,
                                    input int unsigned depth_words);
    if (size == SIZE_ILL)
      return ERR_SIZE;
    else if ((size == SIZE_HALF && addr[0]) ||
             (size == SIZE_WORD && addr[1:0] != 2'b00))
      return ERR_MISALIGN;
    else if ({2'b00, addr[31:2]} >= depth_words)
      return ERR_RANGE;
    else
      return ERR_OK;
  endfunction

endpackage

// File: rtl/data_mem_responder_lane_align.sv
// dmem_lane_align: purely combinational byte-lane steering.
//   Store side: st_size/st_addr_lo/st_wdata -> st_be (byte enables) and
//               st_wword (right-aligned data replicated onto its lanes).
//   Load side : ld_size/ld_addr_lo/ld_sign/ld_rword -> ld_rdata (addressed
//               lanes shifted to bit 0, then zero- or sign-extended).
// Lane n holds byte address n of the word (little-endian).
module dmem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wword,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_addr_lo,
  input  logic        ld_sign,
  input  logic [31:0] ld_rword,
  output logic [31:0] ld_rdata
);

  logic [31:0] shifted;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned (which would infer a latch).
  always_comb begin
    st_be    = 4'b0000;
    st_wword = 32'h0;
    case (st_size)
      SIZE_BYTE: begin
        st_be    = 4'b0001 << st_addr_lo;
        st_wword = {4{st_wdata[7:0]}};
      end
      SIZE_HALF: begin
        st_be    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        st_wword = {2{st_wdata[15:0]}};
      end
      SIZE_WORD: begin
        st_be    = 4'b1111;
        st_wword = st_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted  = ld_rword >> {ld_addr_lo, 3'b000};
    ld_rdata = 32'h0;
    case (ld_size)
      SIZE_BYTE: ld_rdata = {{24{ld_sign & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: ld_rdata = {{16{ld_sign & shifted[15]}}, shifted[15:0]};
      SIZE_WORD: ld_rdata = ld_rword;
      default:   ld_rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding load/store responder in front of a
// DEPTH_WORDS x 32-bit byte-writable memory, with WAIT_STATES (0..15) extra
// cycles between acceptance and response.
//   clk, rst          : clock, asynchronous active-high reset
//   req_valid/ready   : request handshake (ready only while idle)
//   req_we/size/sign  : store/load, access size, load sign-extension
//   req_addr/wdata    : byte address, right-aligned store data
//   rsp_valid/ready   : response handshake
//   rsp_rdata/err     : load result (0 for stores/errors), error code
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q;
  req_t        req_q;
  logic        accept, enter_resp, mem_we;
  logic        acc_we;
  logic [1:0]  acc_size;
  logic [31:0] acc_addr, acc_wdata;
  logic [AW-1:0] acc_idx;
  err_e        acc_err, rsp_err_c;
  logic [3:0]  st_be;
  logic [31:0] st_wword, ld_rdata, rd_word_q;
  logic [31:0] mem [DEPTH_WORDS];

  assign accept = req_valid & req_ready;

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt_q == 4'd0) state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    req_ready = (state_q == ST_IDLE);
    rsp_valid = (state_q == ST_RESP);
    rsp_err   = rsp_valid ? rsp_err_c : ERR_OK;
    rsp_rdata = (rsp_valid && !req_q.we && rsp_err_c == ERR_OK) ? ld_rdata : 32'h0;
  end

  // Wait-state counter: loaded on entry to WAIT, counts down to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= 4'd0;
    else if (state_q == ST_IDLE && state_d == ST_WAIT)
      cnt_q <= WAIT_LOAD;
    else if (state_q == ST_WAIT && cnt_q != 4'd0)
      cnt_q <= cnt_q - 4'd1;
  end

  // Request capture; later changes on req_* are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         req_q <= '0;
    else if (accept) req_q <= '{we: req_we, size: req_size, sign: req_sign,
                                addr: req_addr, wdata: req_wdata};
  end

  // With zero wait states the memory access shares the accept edge, so the
  // live request is used; otherwise the latched copy drives the access.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_we    = req_we;
      acc_size  = req_size;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end else begin
      acc_we    = req_q.we;
      acc_size  = req_q.size;
      acc_addr  = req_q.addr;
      acc_wdata = req_q.wdata;
    end
  end

  assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
  assign acc_err    = calc_err(acc_size, acc_addr, DEPTH_WORDS);
  assign acc_idx    = acc_addr[AW+1:2];
  assign mem_we     = enter_resp && acc_we && (acc_err == ERR_OK);
  assign rsp_err_c  = calc_err(req_q.size, req_q.addr, DEPTH_WORDS);

  dmem_lane_align u_align (
    .st_size    (acc_size),
    .st_addr_lo (acc_addr[1:0]),
    .st_wdata   (acc_wdata),
    .st_be      (st_be),
    .st_wword   (st_wword),
    .ld_size    (req_q.size),
    .ld_addr_lo (req_q.addr[1:0]),
    .ld_sign    (req_q.sign),
    .ld_rword   (rd_word_q),
    .ld_rdata   (ld_rdata)
  );

  // Storage: synchronous read + per-byte write, one access per transaction.
  // NOTE: the array and its read register carry no reset so the memory maps
  // onto block RAM; rsp_rdata is masked by state, so stale read data is never
  // visible.
  always_ff @(posedge clk) begin
    if (enter_resp) begin
      rd_word_q <= mem[acc_idx];
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (st_be[b]) mem[acc_idx][8*b +: 8] <= st_wword[8*b +: 8];
        end
      end
    end
  end

endmodule
